// File: rtl/uart_baud_gen.sv
// uart_baud_gen: dual-channel UART baud strobe generator.
//
// A shared shadow divisor (integer + fractional part) is loaded from the config
// interface. Each channel (TX, RX) keeps its own copy of the divisor, its own
// period counter and its own fractional phase accumulator. A channel only adopts
// a new divisor while it is disabled or at one of its own period boundaries, so
// a load never disturbs a period that is already running.
//
// Fractional division: at the start of every full period the channel adds the
// fractional divisor to its accumulator. The carry-out lengthens that period by
// one cycle, so the long-run average period is div_int + div_frac / 2^FRAC_W.
//
// The RX channel starts every enable with a half period (integer part >> 1, at
// least 1) so that its strobes land in the middle of each bit cell when rx_en is
// raised on the start-bit falling edge. The half period does not advance the
// accumulator.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   div_int    integer divisor, captured on div_load (values < 2 clamp to 2)
//   div_frac   fractional divisor in 1/2^FRAC_W units, captured on div_load
//   div_load   one-cycle strobe capturing div_int/div_frac into the shadow
//   tx_en      TX channel enable; low holds the channel cleared
//   rx_en      RX channel enable; low holds the channel cleared
//   tx_tick    one-cycle registered TX bit-period strobe
//   rx_sample  one-cycle registered RX mid-bit sample strobe
//   div_err    sticky: the most recent load had div_int < 2

module uart_baud_gen #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned FRAC_W  = 4,
  parameter int unsigned DEF_DIV = 625
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              tx_en,
  input  logic              rx_en,
  output logic              tx_tick,
  output logic              rx_sample,
  output logic              div_err
);

  localparam logic [CNT_W-1:0] DefInt = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] MinInt = CNT_W'(2);
  localparam logic [CNT_W-1:0] One    = CNT_W'(1);

  // RX phase: a half period is pending after every (re)enable.
  typedef enum logic {
    RxHalf,
    RxFull
  } rx_phase_e;

  // ---------------------------------------------------------------------------
  // Shadow divisor and error flag
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]  shd_int_q, shd_int_d;
  logic [FRAC_W-1:0] shd_frac_q, shd_frac_d;
  logic              div_err_q, div_err_d;

  always_comb begin
    shd_int_d  = shd_int_q;
    shd_frac_d = shd_frac_q;
    div_err_d  = div_err_q;
    if (div_load) begin
      shd_frac_d = div_frac;
      if (div_int < MinInt) begin
        shd_int_d = MinInt;
        div_err_d = 1'b1;
      end else begin
        shd_int_d = div_int;
        div_err_d = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // TX channel
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]  tx_int_q, tx_int_d;
  logic [FRAC_W-1:0] tx_frac_q, tx_frac_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [FRAC_W-1:0] tx_acc_q, tx_acc_d;
  logic              tx_tick_q, tx_tick_d;
  logic [FRAC_W:0]   tx_sum;
  logic [CNT_W-1:0]  tx_last;
  logic              tx_wrap;

  // The carry of this period's accumulator addition is known from period start,
  // since neither the accumulator nor the active divisor changes mid-period.
  always_comb begin
    tx_sum  = {1'b0, tx_acc_q} + {1'b0, tx_frac_q};
    tx_last = tx_int_q - One + {{(CNT_W-1){1'b0}}, tx_sum[FRAC_W]};
    tx_wrap = tx_en && (tx_cnt_q == tx_last);
  end

  always_comb begin
    tx_int_d  = tx_int_q;
    tx_frac_d = tx_frac_q;
    tx_cnt_d  = tx_cnt_q;
    tx_acc_d  = tx_acc_q;
    tx_tick_d = 1'b0;
    if (!tx_en) begin
      tx_cnt_d  = '0;
      tx_acc_d  = '0;
      tx_int_d  = shd_int_d;
      tx_frac_d = shd_frac_d;
    end else if (tx_wrap) begin
      tx_cnt_d  = '0;
      tx_acc_d  = tx_sum[FRAC_W-1:0];
      tx_tick_d = 1'b1;
      // Take the shadow as it will be after this edge, so a load coinciding
      // with the boundary governs the very next period.
      tx_int_d  = shd_int_d;
      tx_frac_d = shd_frac_d;
    end else begin
      tx_cnt_d = tx_cnt_q + One;
    end
  end

  // ---------------------------------------------------------------------------
  // RX channel
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]  rx_int_q, rx_int_d;
  logic [FRAC_W-1:0] rx_frac_q, rx_frac_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [FRAC_W-1:0] rx_acc_q, rx_acc_d;
  logic              rx_sample_q, rx_sample_d;
  rx_phase_e         rx_phase_q, rx_phase_d;
  logic [FRAC_W:0]   rx_sum;
  logic [CNT_W-1:0]  rx_half_len;
  logic [CNT_W-1:0]  rx_last;
  logic              rx_wrap;

  always_comb begin
    rx_sum      = {1'b0, rx_acc_q} + {1'b0, rx_frac_q};
    rx_half_len = rx_int_q >> 1;
    if (rx_half_len == '0) begin
      rx_half_len = One;
    end
    if (rx_phase_q == RxHalf) begin
      rx_last = rx_half_len - One;
    end else begin
      rx_last = rx_int_q - One + {{(CNT_W-1){1'b0}}, rx_sum[FRAC_W]};
    end
    rx_wrap = rx_en && (rx_cnt_q == rx_last);
  end

  always_comb begin
    rx_int_d    = rx_int_q;
    rx_frac_d   = rx_frac_q;
    rx_cnt_d    = rx_cnt_q;
    rx_acc_d    = rx_acc_q;
    rx_phase_d  = rx_phase_q;
    rx_sample_d = 1'b0;
    if (!rx_en) begin
      rx_cnt_d   = '0;
      rx_acc_d   = '0;
      rx_phase_d = RxHalf;
      rx_int_d   = shd_int_d;
      rx_frac_d  = shd_frac_d;
    end else if (rx_wrap) begin
      rx_cnt_d    = '0;
      rx_sample_d = 1'b1;
      rx_int_d    = shd_int_d;
      rx_frac_d   = shd_frac_d;
      if (rx_phase_q == RxHalf) begin
        // The half period carries no fractional phase.
        rx_phase_d = RxFull;
      end else begin
        rx_acc_d = rx_sum[FRAC_W-1:0];
      end
    end else begin
      rx_cnt_d = rx_cnt_q + One;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_int_q   <= DefInt;
      shd_frac_q  <= '0;
      div_err_q   <= 1'b0;
      tx_int_q    <= DefInt;
      tx_frac_q   <= '0;
      tx_cnt_q    <= '0;
      tx_acc_q    <= '0;
      tx_tick_q   <= 1'b0;
      rx_int_q    <= DefInt;
      rx_frac_q   <= '0;
      rx_cnt_q    <= '0;
      rx_acc_q    <= '0;
      rx_phase_q  <= RxHalf;
      rx_sample_q <= 1'b0;
    end else begin
      shd_int_q   <= shd_int_d;
      shd_frac_q  <= shd_frac_d;
      div_err_q   <= div_err_d;
      tx_int_q    <= tx_int_d;
      tx_frac_q   <= tx_frac_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_acc_q    <= tx_acc_d;
      tx_tick_q   <= tx_tick_d;
      rx_int_q    <= rx_int_d;
      rx_frac_q   <= rx_frac_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_acc_q    <= rx_acc_d;
      rx_phase_q  <= rx_phase_d;
      rx_sample_q <= rx_sample_d;
    end
  end

  assign tx_tick   = tx_tick_q;
  assign rx_sample = rx_sample_q;
  assign div_err   = div_err_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen with DEF_DIV = 8. Each scenario pushes the edge
// numbers at which strobes must appear into per-channel queues, then steps the
// clock and pops an entry whenever a strobe is observed.

module tb_uart_baud_gen;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned FRAC_W  = 4;
  localparam int unsigned DEF_DIV = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CNT_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              tx_en;
  logic              rx_en;
  logic              tx_tick;
  logic              rx_sample;
  logic              div_err;

  int checks = 0;
  int errors = 0;
  int exp_tx[$];
  int exp_rx[$];
  int exp_e;

  uart_baud_gen #(
    .CNT_W  (CNT_W),
    .FRAC_W (FRAC_W),
    .DEF_DIV(DEF_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .div_int  (div_int),
    .div_frac (div_frac),
    .div_load (div_load),
    .tx_en    (tx_en),
    .rx_en    (rx_en),
    .tx_tick  (tx_tick),
    .rx_sample(rx_sample),
    .div_err  (div_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t, required finish before 200000", $time);
    $fatal(1, "timeout");
  end

  // Advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load a divisor with both channels idle; takes one edge.
  task automatic load_div(input int i, input int f);
    div_int  = CNT_W'(i);
    div_frac = FRAC_W'(f);
    div_load = 1'b1;
    step();
    div_load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    div_int = '0; div_frac = '0; div_load = 1'b0; tx_en = 1'b0; rx_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (tx_tick !== 1'b0) begin
      errors++; $display("FAIL reset_tx_tick: got %b, required 0", tx_tick);
    end
    checks++;
    if (rx_sample !== 1'b0) begin
      errors++; $display("FAIL reset_rx_sample: got %b, required 0", rx_sample);
    end
    checks++;
    if (div_err !== 1'b0) begin
      errors++; $display("FAIL reset_div_err: got %b, required 0", div_err);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_tx_basic();
    exp_tx = {8, 16, 24};
    tx_en = 1'b1;
    for (int e = 1; e <= 26; e++) begin
      step();
      if (tx_tick) begin
        checks++;
        if (exp_tx.size() == 0) begin
          errors++; $display("FAIL tx_basic: tick at edge %0d, required none", e);
        end else begin
          exp_e = exp_tx.pop_front();
          if (e !== exp_e) begin
            errors++; $display("FAIL tx_basic: tick at edge %0d, required edge %0d", e, exp_e);
          end
        end
      end
      if (rx_sample) begin
        checks++; errors++; $display("FAIL tx_basic_rx: sample at edge %0d, required none", e);
      end
    end
    checks++;
    if (exp_tx.size() != 0) begin
      errors++; $display("FAIL tx_basic_end: %0d ticks missing, required 0", exp_tx.size());
    end
    exp_tx.delete();
    tx_en = 1'b0;
    step();
  endtask

  task automatic test_rx_basic();
    exp_rx = {4, 12, 20};
    rx_en = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      step();
      if (rx_sample) begin
        checks++;
        if (exp_rx.size() == 0) begin
          errors++; $display("FAIL rx_basic: sample at edge %0d, required none", e);
        end else begin
          exp_e = exp_rx.pop_front();
          if (e !== exp_e) begin
            errors++; $display("FAIL rx_basic: sample at edge %0d, required edge %0d", e, exp_e);
          end
        end
      end
      if (tx_tick) begin
        checks++; errors++; $display("FAIL rx_basic_tx: tick at edge %0d, required none", e);
      end
    end
    checks++;
    if (exp_rx.size() != 0) begin
      errors++; $display("FAIL rx_basic_end: %0d samples missing, required 0", exp_rx.size());
    end
    exp_rx.delete();
    rx_en = 1'b0;
    step();
  endtask

  task automatic test_frac();
    load_div(4, 8);
    exp_tx = {4, 9, 13, 18};
    tx_en = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (tx_tick) begin
        checks++;
        if (exp_tx.size() == 0) begin
          errors++; $display("FAIL frac: tick at edge %0d, required none", e);
        end else begin
          exp_e = exp_tx.pop_front();
          if (e !== exp_e) begin
            errors++; $display("FAIL frac: tick at edge %0d, required edge %0d", e, exp_e);
          end
        end
      end
    end
    checks++;
    if (exp_tx.size() != 0) begin
      errors++; $display("FAIL frac_end: %0d ticks missing, required 0", exp_tx.size());
    end
    exp_tx.delete();
    tx_en = 1'b0;
    step();
    load_div(8, 0);
  endtask

  task automatic test_load_midperiod();
    exp_tx = {8, 12, 16};
    tx_en = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      step();
      if (tx_tick) begin
        checks++;
        if (exp_tx.size() == 0) begin
          errors++; $display("FAIL load_mid: tick at edge %0d, required none", e);
        end else begin
          exp_e = exp_tx.pop_front();
          if (e !== exp_e) begin
            errors++; $display("FAIL load_mid: tick at edge %0d, required edge %0d", e, exp_e);
          end
        end
      end
      if (e == 2) begin
        div_int = CNT_W'(4); div_frac = '0; div_load = 1'b1;
      end
      if (e == 3) div_load = 1'b0;
    end
    checks++;
    if (exp_tx.size() != 0) begin
      errors++; $display("FAIL load_mid_end: %0d ticks missing, required 0", exp_tx.size());
    end
    exp_tx.delete();
    // RX was idle during the load, so it already runs at 4 (half period 2).
    tx_en = 1'b0;
    rx_en = 1'b1;
    exp_rx = {2, 6, 10};
    for (int e = 1; e <= 11; e++) begin
      step();
      if (rx_sample) begin
        checks++;
        if (exp_rx.size() == 0) begin
          errors++; $display("FAIL load_mid_rx: sample at edge %0d, required none", e);
        end else begin
          exp_e = exp_rx.pop_front();
          if (e !== exp_e) begin
            errors++; $display("FAIL load_mid_rx: sample at edge %0d, required edge %0d", e, exp_e);
          end
        end
      end
    end
    checks++;
    if (exp_rx.size() != 0) begin
      errors++; $display("FAIL load_mid_rx_end: %0d samples missing, required 0", exp_rx.size());
    end
    exp_rx.delete();
    rx_en = 1'b0;
    step();
  endtask

  task automatic test_div_err();
    load_div(1, 0);
    checks++;
    if (div_err !== 1'b1) begin
      errors++; $display("FAIL div_err_set: got %b, required 1", div_err);
    end
    exp_tx = {2, 4, 6, 8};
    tx_en = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      step();
      if (tx_tick) begin
        checks++;
        if (exp_tx.size() == 0) begin
          errors++; $display("FAIL div_clamp: tick at edge %0d, required none", e);
        end else begin
          exp_e = exp_tx.pop_front();
          if (e !== exp_e) begin
            errors++; $display("FAIL div_clamp: tick at edge %0d, required edge %0d", e, exp_e);
          end
        end
      end
    end
    checks++;
    if (exp_tx.size() != 0) begin
      errors++; $display("FAIL div_clamp_end: %0d ticks missing, required 0", exp_tx.size());
    end
    exp_tx.delete();
    tx_en = 1'b0;
    load_div(6, 0);
    checks++;
    if (div_err !== 1'b0) begin
      errors++; $display("FAIL div_err_clear: got %b, required 0", div_err);
    end
    exp_tx = {6, 12};
    tx_en = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      step();
      if (tx_tick) begin
        checks++;
        if (exp_tx.size() == 0) begin
          errors++; $display("FAIL div6: tick at edge %0d, required none", e);
        end else begin
          exp_e = exp_tx.pop_front();
          if (e !== exp_e) begin
            errors++; $display("FAIL div6: tick at edge %0d, required edge %0d", e, exp_e);
          end
        end
      end
    end
    checks++;
    if (exp_tx.size() != 0) begin
      errors++; $display("FAIL div6_end: %0d ticks missing, required 0", exp_tx.size());
    end
    exp_tx.delete();
    tx_en = 1'b0;
    step();
  endtask

  task automatic test_enable_drop();
    load_div(8, 0);
    exp_tx = {14};
    exp_rx = {4, 10};
    tx_en = 1'b1;
    rx_en = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      step();
      if (tx_tick) begin
        checks++;
        if (exp_tx.size() == 0) begin
          errors++; $display("FAIL en_drop_tx: tick at edge %0d, required none", e);
        end else begin
          exp_e = exp_tx.pop_front();
          if (e !== exp_e) begin
            errors++; $display("FAIL en_drop_tx: tick at edge %0d, required edge %0d", e, exp_e);
          end
        end
      end
      if (rx_sample) begin
        checks++;
        if (exp_rx.size() == 0) begin
          errors++; $display("FAIL en_drop_rx: sample at edge %0d, required none", e);
        end else begin
          exp_e = exp_rx.pop_front();
          if (e !== exp_e) begin
            errors++; $display("FAIL en_drop_rx: sample at edge %0d, required edge %0d", e, exp_e);
          end
        end
      end
      if (e == 4) begin
        tx_en = 1'b0; rx_en = 1'b0;
      end
      if (e == 6) begin
        tx_en = 1'b1; rx_en = 1'b1;
      end
    end
    checks++;
    if (exp_tx.size() + exp_rx.size() != 0) begin
      errors++;
      $display("FAIL en_drop_end: %0d strobes missing, required 0", exp_tx.size() + exp_rx.size());
    end
    exp_tx.delete();
    exp_rx.delete();
    tx_en = 1'b0;
    rx_en = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    load_div(1, 0);
    tx_en = 1'b1;
    step();
    step();
    checks++;
    if (tx_tick !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre: tx_tick %b, required 1", tx_tick);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx_tick !== 1'b0) begin
      errors++; $display("FAIL rst_mid_tick: tx_tick %b, required 0", tx_tick);
    end
    checks++;
    if (div_err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_err: div_err %b, required 0", div_err);
    end
    rx_en = 1'b1;
    step();
    rst_n = 1'b1;
    // Divisor must be back at the default of 8.
    exp_tx = {8, 16};
    exp_rx = {4, 12};
    for (int e = 1; e <= 17; e++) begin
      step();
      if (tx_tick) begin
        checks++;
        if (exp_tx.size() == 0) begin
          errors++; $display("FAIL rst_mid_tx: tick at edge %0d, required none", e);
        end else begin
          exp_e = exp_tx.pop_front();
          if (e !== exp_e) begin
            errors++; $display("FAIL rst_mid_tx: tick at edge %0d, required edge %0d", e, exp_e);
          end
        end
      end
      if (rx_sample) begin
        checks++;
        if (exp_rx.size() == 0) begin
          errors++; $display("FAIL rst_mid_rx: sample at edge %0d, required none", e);
        end else begin
          exp_e = exp_rx.pop_front();
          if (e !== exp_e) begin
            errors++; $display("FAIL rst_mid_rx: sample at edge %0d, required edge %0d", e, exp_e);
          end
        end
      end
    end
    checks++;
    if (exp_tx.size() + exp_rx.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_end: %0d strobes missing, required 0", exp_tx.size() + exp_rx.size());
    end
    exp_tx.delete();
    exp_rx.delete();
    tx_en = 1'b0;
    rx_en = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_rx_basic();
    test_frac();
    test_load_midperiod();
    test_div_err();
    test_enable_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
Dual-channel UART baud tick generator, the parametrised successor to the fixed-divisor baud tick block. It supports a runtime-programmable integer-plus-fractional divisor and has independent TX and RX channels. The RX channel emits mid-bit sample strobes. It sits between the register/config interface and the UART TX/RX shift-register FSMs, which consume one-cycle strobes.

Parameters:
CNT_W, 16, width of integer divisor and period counters.
FRAC_W, 4, width of fractional divisor and per-channel phase accumulators.
DEF_DIV, 625, integer divisor after reset. Must satisfy 2 <= DEF_DIV < 2^CNT_W.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous, active-low reset.
div_int  in  CNT_W  integer divisor; sampled on div_load.
div_frac  in  FRAC_W  fractional divisor, in units of 1/2^FRAC_W; sampled on div_load.
div_load  in  1  one-cycle strobe that captures div_int/div_frac into the shadow register.
tx_en  in  1  TX channel enable; low clears the channel.
rx_en  in  1  RX channel enable; low clears the channel.
tx_tick  out  1  one-cycle TX bit-period strobe, registered.
rx_sample  out  1  one-cycle RX mid-bit sample strobe, registered.
div_err  out  1  sticky flag: last loaded div_int was < 2.

Behaviour:
- Reset (async) values:
  - tx_tick=0, rx_sample=0, div_err=0.
  - Shadow divisor = {DEF_DIV, 0}.
  - Both channel counters and accumulators = 0.
  - Both channel active divisors = {DEF_DIV, 0}.
- div_load:
  - Shadow is captured at the next edge.
  - If div_int < 2: shadow integer is clamped to 2 and div_err is set. A later load with div_int >= 2 clears div_err.
  - div_frac is taken as-is.
- Active divisor update, per channel:
  - Copies the shadow while the channel is disabled.
  - Otherwise copies it only at that channel's period boundary.
  - A load therefore never truncates or stretches a period in progress. The new value governs the next full period.
  - Same-cycle load and boundary: the boundary uses the old value; the next period uses the new one.
- Period length P:
  - At each period boundary, acc_next = acc + frac (FRAC_W-bit wrap).
  - The period just ending lasted div_int + carry-out of that addition. Equivalently, the carry is computed at period start: add frac to acc when the period begins, and P = div_int + carry.
  - Long-run average period = div_int + frac/2^FRAC_W.
  - frac=0 gives exactly div_int every period.
- TX channel:
  - While tx_en=0: counter=0, acc=0, tx_tick=0 from the next edge.
  - While tx_en=1: counter increments each edge. When counter==P-1 it wraps to 0 and tx_tick is registered high for exactly one cycle.
  - First tick follows the P-th rising edge at which tx_en is sampled high. Subsequent ticks are spaced by each following P.
- RX channel:
  - Same counter structure as TX.
  - The first period after rx_en rises is a half period H = div_int >> 1 (integer part only, minimum 1). The accumulator is not advanced for this half period.
  - rx_sample pulses after the H-th edge with rx_en high, then every full P thereafter. This centres each strobe in a bit cell when rx_en is raised at the start-bit falling edge.
- Channels are fully independent. Simultaneous ticks on both outputs are legal.
- Enable deasserted mid-period: counter, acc and half-period flag clear. No strobe is issued for the partial period. Re-enable restarts from zero (RX starts again with a half period).
- Reset mid-operation: all state returns to reset values immediately. The divisor reverts to DEF_DIV, discarding any loaded value.
- Counter width CNT_W; max P = 2^CNT_W - 1 + 1. Counter never exceeds P-1 and has no overflow path.

Test Plan:
- DEF_DIV=8, reset released, tx_en=1 from edge 1 -> tx_tick high after edges 8, 16, 24; low on all other cycles.
- DEF_DIV=8, rx_en=1 from edge 1 -> rx_sample after edges 4, 12, 20.
- Load div_int=4, div_frac=8 (FRAC_W=4), then tx_en=1 -> periods alternate 4,5: ticks after edges 4, 9, 13, 18.
- TX running at div 8; div_load with div_int=4 at edge 3 -> tick still at edge 8, then 12, 16. RX channel is disabled at load and picks up 4 immediately.
- div_load with div_int=1 -> div_err=1, period=2 (ticks every 2 edges); reload div_int=6 -> div_err=0, period 6.
- tx_en dropped at edge 5 of an 8-period, re-raised at edge 7 -> no tick at 8, next tick after edge 14. rst_n pulsed mid-period -> outputs 0 asynchronously, divisor back to DEF_DIV.
